// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: debounced single-step / free-run enable generator for the core
module cpu_step_ctrl #(
  parameter int DEB_BITS    = 20,
  parameter int RUN_DIV     = 26,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             sw_run,
  input  logic             halt,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_cnt
);
  typedef enum logic [1:0] {STEP = 2'b00, RUN = 2'b01, HALTED = 2'b10} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d, run_sync_q, run_sync_d;
  logic [DEB_BITS-1:0]    deb_q, deb_d;
  logic [RUN_DIV-1:0]     div_q, div_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d, en_q, en_d;
  logic                   btn_s, run_s, press, tick;
  assign btn_s    = btn_sync_q[SYNC_STAGES-1];
  assign run_s    = run_sync_q[SYNC_STAGES-1];
  assign cpu_en   = en_q;
  assign mode     = state_q;
  assign step_cnt = cnt_q;
  always_comb begin
    btn_sync_d = {btn_sync_q[SYNC_STAGES-2:0], btn_step};
    run_sync_d = {run_sync_q[SYNC_STAGES-2:0], sw_run};
    deb_d      = (btn_s == stable_q || &deb_q) ? '0 : deb_q + 1'b1;
    stable_d   = (btn_s != stable_q && &deb_q) ? btn_s : stable_q;
    press      = stable_d & ~stable_q;
    div_d      = div_q + 1'b1;
    tick       = div_q == '0;
    state_d    = state_q;
    en_d       = 1'b0;
    case (state_q)
      STEP:    if (run_s) state_d = RUN; else en_d = press;
      RUN:     if (!run_s) state_d = STEP; else if (halt) state_d = HALTED; else en_d = tick;
      default: if (!run_s) state_d = STEP;
    endcase
    cnt_d = cnt_q + CNT_W'(en_d);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_sync_q <= '0;
      run_sync_q <= '0;
      deb_q      <= '0;
      stable_q   <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      state_q    <= STEP;
    end else begin
      btn_sync_q <= btn_sync_d;
      run_sync_q <= run_sync_d;
      deb_q      <= deb_d;
      stable_q   <= stable_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      state_q    <= state_d;
    end
  end
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: scoreboard bench for cpu_step_ctrl with small debounce/divider widths
module tb_cpu_step_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_step = 1'b0;
  logic       sw_run = 1'b0;
  logic       halt = 1'b0;
  logic       cpu_en;
  logic [1:0] mode;
  logic [3:0] step_cnt;
  int         tests = 0, fails = 0, pulses = 0, cyc = 0, last_pc = 0;
  logic       prev_en = 1'b0;
  logic [3:0] exp_cnt = 4'd0;
  logic [3:0] exp_q[$];

  cpu_step_ctrl #(.DEB_BITS(4), .RUN_DIV(3), .SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .btn_step(btn_step), .sw_run(sw_run), .halt(halt),
    .cpu_en(cpu_en), .mode(mode), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_pulse();
    exp_cnt = exp_cnt + 4'd1;
    exp_q.push_back(exp_cnt);
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (reset) begin
      if (cpu_en) begin
        pulses++;
        last_pc = cyc;
        chk("en_consecutive", {31'd0, prev_en}, 0);
        chk("pulse_expected", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("step_cnt_at_pulse", {28'd0, step_cnt}, {28'd0, e});
        end
      end
      prev_en = cpu_en;
    end
  end

  task automatic do_reset();
    btn_step = 1'b0;
    sw_run   = 1'b0;
    halt     = 1'b0;
    reset    = 1'b0;
    exp_q.delete();
    exp_cnt  = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget && pulses < n; i++) begin
      @(negedge clk);
      #1;
    end
    chk("wait_pulse", {31'd0, pulses >= n}, 1);
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget);
    for (int i = 0; i < budget && mode !== m; i++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_mode", {30'd0, mode}, {30'd0, m});
  endtask

  initial begin
    int cyc0, p0, prev;
    #1;
    chk("rst_cpu_en", {31'd0, cpu_en}, 0);
    chk("rst_mode", {30'd0, mode}, 0);
    chk("rst_step_cnt", {28'd0, step_cnt}, 0);

    // 1: bouncing button, then a clean hold; 2 sync + 15 debounce + 1 register
    do_reset();
    for (int i = 0; i < 8; i++) begin
      btn_step = ~btn_step;
      repeat (5) @(posedge clk);
      #1;
    end
    btn_step = 1'b1;
    cyc0 = cyc;
    push_pulse();
    wait_pulses(1, 40);
    chk("bounce_latency", last_pc - cyc0, 18);
    chk("bounce_step_cnt", {28'd0, step_cnt}, 1);
    chk("bounce_mode", {30'd0, mode}, 0);
    btn_step = 1'b0;
    repeat (30) @(posedge clk);
    chk("bounce_single", pulses, 1);

    // 2: free-run, one enable every 8 cycles
    do_reset();
    sw_run = 1'b1;
    @(posedge clk); #1;
    chk("run_mode_early", {30'd0, mode}, 0);
    repeat (2) @(posedge clk); #1;
    chk("run_mode", {30'd0, mode}, 1);
    p0 = pulses;
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      push_pulse();
      wait_pulses(p0 + k + 1, 20);
      if (k > 0) chk("run_period", last_pc - prev, 8);
      prev = last_pc;
    end
    sw_run = 1'b0;
    chk("run_step_cnt", {28'd0, step_cnt}, 10);
    repeat (20) @(posedge clk); #1;
    chk("run_pulses", pulses - p0, 10);
    chk("run_back_step", {30'd0, mode}, 0);

    // 3: halt while running, presses ignored, leave only via sw_run=0
    do_reset();
    sw_run = 1'b1;
    wait_mode(2'b01, 10);
    halt = 1'b1;
    @(posedge clk); #1;
    chk("halt_mode", {30'd0, mode}, 2);
    halt = 1'b0;
    p0 = pulses;
    repeat (5) @(posedge clk); #1;
    chk("halt_sticky", {30'd0, mode}, 2);
    btn_step = 1'b1;
    repeat (30) @(posedge clk);
    btn_step = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("halt_no_pulse", pulses - p0, 0);
    chk("halt_mode_hold", {30'd0, mode}, 2);
    sw_run = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("halt_exit", {30'd0, mode}, 0);

    // 4: sixteen clean presses, counter wraps 15 -> 0
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 16; k++) begin
      push_pulse();
      btn_step = 1'b1;
      wait_pulses(p0 + k + 1, 30);
      btn_step = 1'b0;
      repeat (25) @(posedge clk);
    end
    #1;
    chk("wrap_pulses", pulses - p0, 16);
    chk("wrap_step_cnt", {28'd0, step_cnt}, 0);

    // 5: press and run_s rise in the same cycle; the press is dropped
    do_reset();
    p0 = pulses;
    btn_step = 1'b1;
    repeat (15) @(posedge clk); #1;
    sw_run = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("race_mode", {30'd0, mode}, 1);
    sw_run = 1'b0;
    btn_step = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("race_no_pulse", pulses - p0, 0);

    // 6: async reset mid-pulse while running
    do_reset();
    sw_run = 1'b1;
    p0 = pulses;
    push_pulse();
    push_pulse();
    wait_pulses(p0 + 2, 40);
    #1 reset = 1'b0;
    #1;
    chk("arst_cpu_en", {31'd0, cpu_en}, 0);
    chk("arst_mode", {30'd0, mode}, 0);
    chk("arst_step_cnt", {28'd0, step_cnt}, 0);
    sw_run = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    p0 = pulses;
    repeat (20) @(posedge clk); #1;
    chk("arst_no_pulse", pulses - p0, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
